// File: rtl/ads1672_sample_buffer.sv
// Receive buffer for ADS1672 conversion words: tags each sample with a wrapping
// sequence number and queues it in a first-word-fall-through FIFO, counting drops.
module ads1672_sample_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int SEQ_WIDTH  = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic [SEQ_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  input  logic                          clear_ovf
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = SEQ_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [SEQ_WIDTH-1:0] seq;

  logic push_try;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_try = in_valid && enable;
    pop      = out_valid && out_ready;
    full     = (level == LVL_W'(DEPTH));
    accept   = push_try && (!full || pop);
    drop     = push_try && full && !pop;
  end

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Memory is reset so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= {seq, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // The tag advances on every attempted push, so dropped samples leave gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (!enable) begin
      seq <= '0;
    end else if (push_try) begin
      seq <= seq + SEQ_WIDTH'(1);
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)
        drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_ads1672_sample_buffer.sv
// Directed self-checking bench for ads1672_sample_buffer (DATA 24, SEQ 8, DEPTH 16).
module tb_ads1672_sample_buffer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  ads1672_sample_buffer #(.DATA_WIDTH(24), .SEQ_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [23:0] d);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %0b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h expected 00000000", out_data); end
    tests_run++;
    if (level !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_level got %0d expected 0", level); end
    tests_run++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL reset_status got ovf=%0b drops=%0d expected 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_one(24'h123456);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h00123456 || level !== 5'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_first got v=%0b d=%h l=%0d expected 1/00123456/1", out_valid, out_data, level);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL basic_pop got v=%0b l=%0d expected 0/0", out_valid, level);
    end
    push_one(24'hABCDEF);
    tests_run++;
    if (out_data !== 32'h01ABCDEF) begin
      tests_failed++; $display("[TB] FAIL basic_second got %h expected 01ABCDEF", out_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) push_one(24'h200000 + 24'(i));
    tests_run++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status got l=%0d ovf=%0b drops=%0d expected 16/1/4", level, overflow, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = {8'(i), 24'h200000 + 24'(i)};
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        tests_failed++; $display("[TB] FAIL ovf_drain[%0d] got v=%0b d=%h expected 1/%h", i, out_valid, out_data, exp);
      end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL ovf_empty got v=%0b l=%0d expected 0/0", out_valid, level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) push_one(24'h100000 + 24'(i));
    in_data = 24'hFEED00; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (level !== 5'd16 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_status got l=%0d drops=%0d ovf=%0b expected 16/0/0", level, drop_count, overflow);
    end
    for (int k = 1; k <= 16; k++) begin
      exp = (k == 16) ? 32'h10FEED00 : {8'(k), 24'h100000 + 24'(k)};
      tests_run++;
      if (out_data !== exp) begin
        tests_failed++; $display("[TB] FAIL fullpp_drain[%0d] got %h expected %h", k, out_data, exp);
      end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fullpp_empty got %0b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 24'h300000 + 24'(i); in_valid = 1'b1;
      step();
      exp = {8'(i), 24'h300000 + 24'(i)};
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp || level !== 5'd1) begin
        tests_failed++;
        $display("[TB] FAIL b2b[%0d] got v=%0b d=%h l=%0d expected 1/%h/1", i, out_valid, out_data, level, exp);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_end got v=%0b drops=%0d ovf=%0b expected 0/0/0", out_valid, drop_count, overflow);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 16; i++) push_one(24'(i));
    in_valid = 1'b1;
    repeat (70000) step();
    in_valid = 1'b0;
    tests_run++;
    if (drop_count !== 16'hFFFF || overflow !== 1'b1 || level !== 5'd16) begin
      tests_failed++;
      $display("[TB] FAIL saturate got drops=%h ovf=%0b l=%0d expected FFFF/1/16", drop_count, overflow, level);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 19; i++) push_one(24'(i));
    tests_run++;
    if (drop_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL clear_pre got %0d expected 3", drop_count); end
    in_data = 24'h777777; in_valid = 1'b1; clear_ovf = 1'b1;
    step();
    in_valid = 1'b0; clear_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || drop_count !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL clear_with_drop got ovf=%0b drops=%0d expected 1/1", overflow, drop_count);
    end
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL clear_alone got ovf=%0b drops=%0d expected 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(24'h400000 + 24'(i));
    tests_run++;
    if (level !== 5'd5) begin tests_failed++; $display("[TB] FAIL areset_pre got %0d expected 5", level); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 5'd0 || out_data !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL areset_now got v=%0b l=%0d d=%h expected 0/0/00000000", out_valid, level, out_data);
    end
    #3 rst_n = 1'b1;
    push_one(24'h555555);
    tests_run++;
    if (out_data !== 32'h00555555) begin
      tests_failed++; $display("[TB] FAIL areset_seq got %h expected 00555555", out_data);
    end
  endtask

  task automatic test_disable();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_one(24'h666666);
    tests_run++;
    if (level !== 5'd0 || out_valid !== 1'b0 || drop_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL disable_ignore got l=%0d v=%0b drops=%0d expected 0/0/0", level, out_valid, drop_count);
    end
    enable = 1'b1;
    push_one(24'h0000AA);
    push_one(24'h0000BB);
    enable = 1'b0;
    push_one(24'h0000CC);
    tests_run++;
    if (level !== 5'd2) begin tests_failed++; $display("[TB] FAIL disable_keep got %0d expected 2", level); end
    enable = 1'b1;
    push_one(24'h0000DD);
    out_ready = 1'b1;
    tests_run++;
    if (out_data !== 32'h000000AA) begin tests_failed++; $display("[TB] FAIL disable_d0 got %h expected 000000AA", out_data); end
    step();
    tests_run++;
    if (out_data !== 32'h010000BB) begin tests_failed++; $display("[TB] FAIL disable_d1 got %h expected 010000BB", out_data); end
    step();
    tests_run++;
    if (out_data !== 32'h000000DD) begin tests_failed++; $display("[TB] FAIL disable_d2 got %h expected 000000DD", out_data); end
    step();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL disable_empty got %0b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_saturate();
    test_clear();
    test_async_reset();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
